uart_rx_fifo: RTL

Receive-side byte buffer sitting directly downstream of `uart_rx`. Captures each byte presented on `din` when `rx_done_tick` pulses, stores up to 2^ADDR_W bytes in a circular buffer, and hands them to the consumer through a simple read-strobe interface. Reports occupancy, full and empty status, and a sticky overflow flag for bytes dropped while full.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_fifo_mem.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default receive-FIFO depth and the data-byte type.
package uart_pkg;

  localparam int unsigned UART_DBIT        = 8;
  localparam int unsigned UART_FIFO_ADDR_W = 4;

  typedef logic [UART_DBIT-1:0] uart_data_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-file storage for the UART receive FIFO. It has one synchronous write port and one
// read port.
// Macro UART_RX_FIFO_FWFT_EN selects a combinational read port. Otherwise the read port is a
// registered output that is loaded on i_re.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DBIT   = UART_DBIT,
  parameter int unsigned ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DBIT-1:0]   i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DBIT-1:0]   o_rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DBIT-1:0] r_mem [Depth];

  // Array write; contents are not reset because empty/count gate their visibility.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  assign o_rdata = r_mem[i_raddr];

  // The read strobe and reset only matter to the registered read port.
  logic w_unused;
  assign w_unused = ^{i_re, i_rst_n};
`else
  logic [DBIT-1:0] r_rdata;

  // Registered read port. If a read and a write hit the same address, the read returns the
  // old contents, which is the byte at the head of a full FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO downstream of uart_rx. It captures din on rx_done_tick and serves the
// bytes through a read strobe. It reports count, full, empty and a sticky overflow flag.
// Macro UART_RX_FIFO_FWFT_EN selects first-word-fall-through reads. Otherwise reads are
// registered, and rd_valid pulses one cycle after an accepted read.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBIT   = UART_DBIT,
  parameter int unsigned ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_done_tick,
  input  logic [DBIT-1:0]   i_din,
  input  logic              i_rd,
  output logic [DBIT-1:0]   o_rd_data,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  input  logic              i_ovf_clr
);

  localparam logic [ADDR_W:0] Depth = (ADDR_W+1)'(1) << ADDR_W;

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              w_empty;
  logic              w_full;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_drop;
  logic [DBIT-1:0]   w_mem_rdata;

  // Status decoded from the registered count only.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == Depth);

  // Handshake: a read frees a slot in the same cycle, so a tick while full still lands.
  assign w_rd_ok = i_rd & ~w_empty;
  assign w_wr_ok = i_rx_done_tick & (~w_full | w_rd_ok);
  assign w_drop  = i_rx_done_tick & w_full & ~w_rd_ok;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + ADDR_W'(1);
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + ADDR_W'(1);
      end
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr),
    .i_wdata (i_din),
    .i_re    (w_rd_ok),
    .i_raddr (r_rptr),
    .o_rdata (w_mem_rdata)
  );

`ifdef UART_RX_FIFO_FWFT_EN
  // The head byte is shown while data is stored. The output is forced to zero when empty so
  // that stale array contents never appear.
  assign o_rd_valid = ~w_empty;
  assign o_rd_data  = w_empty ? '0 : w_mem_rdata;
`else
  logic r_rd_valid;

  // One-cycle valid pulse that follows each accepted read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = w_mem_rdata;
`endif

  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
